// File: rtl/wb_arbiter_2m.sv
// Two-master pipelined Wishbone arbiter: grant held for a whole cyc, bounded outstanding requests.
// Define WB_ARBITER_FIXED_PRIORITY_EN for m0-wins contention; default build is round robin.
module wb_arbiter_2m #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic        m0_ack_o,
   output logic        m0_stall_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic        m1_ack_o,
   output logic        m1_stall_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_stall_i,
   output logic [1:0]  grant_o
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [3:0] count_q, count_d;

   logic full, own_cyc, own_stb, accept, ack_dec, winner;

   assign full    = (count_q == MAX_CNT);
   assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
   assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
   assign accept  = (state_q == BUSY) & own_cyc & own_stb & ~full & ~s_stall_i;
   assign ack_dec = s_ack_i & (count_q != 4'd0);

`ifdef WB_ARBITER_FIXED_PRIORITY_EN
   assign winner = ~m0_cyc_i;
`else
   assign winner = (m0_cyc_i & m1_cyc_i) ? ~last_q : m1_cyc_i;
`endif

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         count_q <= 4'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i | m1_cyc_i) begin
               state_d = BUSY;
               owner_d = winner;
               last_d  = winner;
               count_d = 4'd0;
            end
         end
         BUSY: begin
            // Dropping cyc abandons the cycle; in-flight acks are discarded.
            if (!own_cyc) begin
               state_d = IDLE;
               count_d = 4'd0;
            end else begin
               count_d = count_q + {3'd0, accept} - {3'd0, ack_dec};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o    = 32'd0;
      s_dat_o    = 32'd0;
      s_we_o     = 1'b0;
      s_sel_o    = 4'd0;
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      m0_stall_o = 1'b1;
      m1_stall_o = 1'b1;
      m0_ack_o   = 1'b0;
      m1_ack_o   = 1'b0;
      grant_o    = 2'b00;
      if (state_q == BUSY) begin
         s_adr_o = owner_q ? m1_adr_i : m0_adr_i;
         s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
         s_we_o  = owner_q ? m1_we_i  : m0_we_i;
         s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
         s_cyc_o = own_cyc;
         s_stb_o = own_stb & ~full;
         if (owner_q) begin
            m1_stall_o = s_stall_i | full;
            m1_ack_o   = s_ack_i;
            grant_o    = 2'b10;
         end else begin
            m0_stall_o = s_stall_i | full;
            m0_ack_o   = s_ack_i;
            grant_o    = 2'b01;
         end
      end
   end

endmodule
